// File: rtl/sub_bytes_iter.sv
// sub_bytes_iter: iterative AES-128 SubBytes stage (feeds ShiftRows).
// Each BUSY cycle pushes LANES bytes of the work register through LANES
// S-box copies, lowest-numbered bytes first. One block takes 16/LANES cycles.
// Ports:
//   CLK, RST             clock; async active-high reset
//   Data_in, in_valid    128-bit state in, byte Bk at [8k-1:8k-8]
//   in_ready             high in IDLE only
//   Data_out, out_valid  substituted state; valid in DONE only
//   out_ready            downstream accept
// in_ready/out_valid are decoded from the state register only, so there is
// no combinational path from in_valid/out_ready to any output.

module sub_bytes_sbox (
  input  logic [7:0] i_byte,
  output logic [7:0] o_byte
);
  // FIPS-197 forward S-box
  always_comb begin
    o_byte = 8'h00;
    case (i_byte)
      8'h00: o_byte = 8'h63; 8'h01: o_byte = 8'h7c; 8'h02: o_byte = 8'h77; 8'h03: o_byte = 8'h7b; 8'h04: o_byte = 8'hf2; 8'h05: o_byte = 8'h6b; 8'h06: o_byte = 8'h6f; 8'h07: o_byte = 8'hc5;
      8'h08: o_byte = 8'h30; 8'h09: o_byte = 8'h01; 8'h0a: o_byte = 8'h67; 8'h0b: o_byte = 8'h2b; 8'h0c: o_byte = 8'hfe; 8'h0d: o_byte = 8'hd7; 8'h0e: o_byte = 8'hab; 8'h0f: o_byte = 8'h76;
      8'h10: o_byte = 8'hca; 8'h11: o_byte = 8'h82; 8'h12: o_byte = 8'hc9; 8'h13: o_byte = 8'h7d; 8'h14: o_byte = 8'hfa; 8'h15: o_byte = 8'h59; 8'h16: o_byte = 8'h47; 8'h17: o_byte = 8'hf0;
      8'h18: o_byte = 8'had; 8'h19: o_byte = 8'hd4; 8'h1a: o_byte = 8'ha2; 8'h1b: o_byte = 8'haf; 8'h1c: o_byte = 8'h9c; 8'h1d: o_byte = 8'ha4; 8'h1e: o_byte = 8'h72; 8'h1f: o_byte = 8'hc0;
      8'h20: o_byte = 8'hb7; 8'h21: o_byte = 8'hfd; 8'h22: o_byte = 8'h93; 8'h23: o_byte = 8'h26; 8'h24: o_byte = 8'h36; 8'h25: o_byte = 8'h3f; 8'h26: o_byte = 8'hf7; 8'h27: o_byte = 8'hcc;
      8'h28: o_byte = 8'h34; 8'h29: o_byte = 8'ha5; 8'h2a: o_byte = 8'he5; 8'h2b: o_byte = 8'hf1; 8'h2c: o_byte = 8'h71; 8'h2d: o_byte = 8'hd8; 8'h2e: o_byte = 8'h31; 8'h2f: o_byte = 8'h15;
      8'h30: o_byte = 8'h04; 8'h31: o_byte = 8'hc7; 8'h32: o_byte = 8'h23; 8'h33: o_byte = 8'hc3; 8'h34: o_byte = 8'h18; 8'h35: o_byte = 8'h96; 8'h36: o_byte = 8'h05; 8'h37: o_byte = 8'h9a;
      8'h38: o_byte = 8'h07; 8'h39: o_byte = 8'h12; 8'h3a: o_byte = 8'h80; 8'h3b: o_byte = 8'he2; 8'h3c: o_byte = 8'heb; 8'h3d: o_byte = 8'h27; 8'h3e: o_byte = 8'hb2; 8'h3f: o_byte = 8'h75;
      8'h40: o_byte = 8'h09; 8'h41: o_byte = 8'h83; 8'h42: o_byte = 8'h2c; 8'h43: o_byte = 8'h1a; 8'h44: o_byte = 8'h1b; 8'h45: o_byte = 8'h6e; 8'h46: o_byte = 8'h5a; 8'h47: o_byte = 8'ha0;
      8'h48: o_byte = 8'h52; 8'h49: o_byte = 8'h3b; 8'h4a: o_byte = 8'hd6; 8'h4b: o_byte = 8'hb3; 8'h4c: o_byte = 8'h29; 8'h4d: o_byte = 8'he3; 8'h4e: o_byte = 8'h2f; 8'h4f: o_byte = 8'h84;
      8'h50: o_byte = 8'h53; 8'h51: o_byte = 8'hd1; 8'h52: o_byte = 8'h00; 8'h53: o_byte = 8'hed; 8'h54: o_byte = 8'h20; 8'h55: o_byte = 8'hfc; 8'h56: o_byte = 8'hb1; 8'h57: o_byte = 8'h5b;
      8'h58: o_byte = 8'h6a; 8'h59: o_byte = 8'hcb; 8'h5a: o_byte = 8'hbe; 8'h5b: o_byte = 8'h39; 8'h5c: o_byte = 8'h4a; 8'h5d: o_byte = 8'h4c; 8'h5e: o_byte = 8'h58; 8'h5f: o_byte = 8'hcf;
      8'h60: o_byte = 8'hd0; 8'h61: o_byte = 8'hef; 8'h62: o_byte = 8'haa; 8'h63: o_byte = 8'hfb; 8'h64: o_byte = 8'h43; 8'h65: o_byte = 8'h4d; 8'h66: o_byte = 8'h33; 8'h67: o_byte = 8'h85;
      8'h68: o_byte = 8'h45; 8'h69: o_byte = 8'hf9; 8'h6a: o_byte = 8'h02; 8'h6b: o_byte = 8'h7f; 8'h6c: o_byte = 8'h50; 8'h6d: o_byte = 8'h3c; 8'h6e: o_byte = 8'h9f; 8'h6f: o_byte = 8'ha8;
      8'h70: o_byte = 8'h51; 8'h71: o_byte = 8'ha3; 8'h72: o_byte = 8'h40; 8'h73: o_byte = 8'h8f; 8'h74: o_byte = 8'h92; 8'h75: o_byte = 8'h9d; 8'h76: o_byte = 8'h38; 8'h77: o_byte = 8'hf5;
      8'h78: o_byte = 8'hbc; 8'h79: o_byte = 8'hb6; 8'h7a: o_byte = 8'hda; 8'h7b: o_byte = 8'h21; 8'h7c: o_byte = 8'h10; 8'h7d: o_byte = 8'hff; 8'h7e: o_byte = 8'hf3; 8'h7f: o_byte = 8'hd2;
      8'h80: o_byte = 8'hcd; 8'h81: o_byte = 8'h0c; 8'h82: o_byte = 8'h13; 8'h83: o_byte = 8'hec; 8'h84: o_byte = 8'h5f; 8'h85: o_byte = 8'h97; 8'h86: o_byte = 8'h44; 8'h87: o_byte = 8'h17;
      8'h88: o_byte = 8'hc4; 8'h89: o_byte = 8'ha7; 8'h8a: o_byte = 8'h7e; 8'h8b: o_byte = 8'h3d; 8'h8c: o_byte = 8'h64; 8'h8d: o_byte = 8'h5d; 8'h8e: o_byte = 8'h19; 8'h8f: o_byte = 8'h73;
      8'h90: o_byte = 8'h60; 8'h91: o_byte = 8'h81; 8'h92: o_byte = 8'h4f; 8'h93: o_byte = 8'hdc; 8'h94: o_byte = 8'h22; 8'h95: o_byte = 8'h2a; 8'h96: o_byte = 8'h90; 8'h97: o_byte = 8'h88;
      8'h98: o_byte = 8'h46; 8'h99: o_byte = 8'hee; 8'h9a: o_byte = 8'hb8; 8'h9b: o_byte = 8'h14; 8'h9c: o_byte = 8'hde; 8'h9d: o_byte = 8'h5e; 8'h9e: o_byte = 8'h0b; 8'h9f: o_byte = 8'hdb;
      8'ha0: o_byte = 8'he0; 8'ha1: o_byte = 8'h32; 8'ha2: o_byte = 8'h3a; 8'ha3: o_byte = 8'h0a; 8'ha4: o_byte = 8'h49; 8'ha5: o_byte = 8'h06; 8'ha6: o_byte = 8'h24; 8'ha7: o_byte = 8'h5c;
      8'ha8: o_byte = 8'hc2; 8'ha9: o_byte = 8'hd3; 8'haa: o_byte = 8'hac; 8'hab: o_byte = 8'h62; 8'hac: o_byte = 8'h91; 8'had: o_byte = 8'h95; 8'hae: o_byte = 8'he4; 8'haf: o_byte = 8'h79;
      8'hb0: o_byte = 8'he7; 8'hb1: o_byte = 8'hc8; 8'hb2: o_byte = 8'h37; 8'hb3: o_byte = 8'h6d; 8'hb4: o_byte = 8'h8d; 8'hb5: o_byte = 8'hd5; 8'hb6: o_byte = 8'h4e; 8'hb7: o_byte = 8'ha9;
      8'hb8: o_byte = 8'h6c; 8'hb9: o_byte = 8'h56; 8'hba: o_byte = 8'hf4; 8'hbb: o_byte = 8'hea; 8'hbc: o_byte = 8'h65; 8'hbd: o_byte = 8'h7a; 8'hbe: o_byte = 8'hae; 8'hbf: o_byte = 8'h08;
      8'hc0: o_byte = 8'hba; 8'hc1: o_byte = 8'h78; 8'hc2: o_byte = 8'h25; 8'hc3: o_byte = 8'h2e; 8'hc4: o_byte = 8'h1c; 8'hc5: o_byte = 8'ha6; 8'hc6: o_byte = 8'hb4; 8'hc7: o_byte = 8'hc6;
      8'hc8: o_byte = 8'he8; 8'hc9: o_byte = 8'hdd; 8'hca: o_byte = 8'h74; 8'hcb: o_byte = 8'h1f; 8'hcc: o_byte = 8'h4b; 8'hcd: o_byte = 8'hbd; 8'hce: o_byte = 8'h8b; 8'hcf: o_byte = 8'h8a;
      8'hd0: o_byte = 8'h70; 8'hd1: o_byte = 8'h3e; 8'hd2: o_byte = 8'hb5; 8'hd3: o_byte = 8'h66; 8'hd4: o_byte = 8'h48; 8'hd5: o_byte = 8'h03; 8'hd6: o_byte = 8'hf6; 8'hd7: o_byte = 8'h0e;
      8'hd8: o_byte = 8'h61; 8'hd9: o_byte = 8'h35; 8'hda: o_byte = 8'h57; 8'hdb: o_byte = 8'hb9; 8'hdc: o_byte = 8'h86; 8'hdd: o_byte = 8'hc1; 8'hde: o_byte = 8'h1d; 8'hdf: o_byte = 8'h9e;
      8'he0: o_byte = 8'he1; 8'he1: o_byte = 8'hf8; 8'he2: o_byte = 8'h98; 8'he3: o_byte = 8'h11; 8'he4: o_byte = 8'h69; 8'he5: o_byte = 8'hd9; 8'he6: o_byte = 8'h8e; 8'he7: o_byte = 8'h94;
      8'he8: o_byte = 8'h9b; 8'he9: o_byte = 8'h1e; 8'hea: o_byte = 8'h87; 8'heb: o_byte = 8'he9; 8'hec: o_byte = 8'hce; 8'hed: o_byte = 8'h55; 8'hee: o_byte = 8'h28; 8'hef: o_byte = 8'hdf;
      8'hf0: o_byte = 8'h8c; 8'hf1: o_byte = 8'ha1; 8'hf2: o_byte = 8'h89; 8'hf3: o_byte = 8'h0d; 8'hf4: o_byte = 8'hbf; 8'hf5: o_byte = 8'he6; 8'hf6: o_byte = 8'h42; 8'hf7: o_byte = 8'h68;
      8'hf8: o_byte = 8'h41; 8'hf9: o_byte = 8'h99; 8'hfa: o_byte = 8'h2d; 8'hfb: o_byte = 8'h0f; 8'hfc: o_byte = 8'hb0; 8'hfd: o_byte = 8'h54; 8'hfe: o_byte = 8'hbb; 8'hff: o_byte = 8'h16;
    endcase
  end
endmodule

module sub_bytes_iter #(
  parameter int LANES = 4
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic [127:0] Data_in,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [127:0] Data_out,
  output logic         out_valid,
  input  logic         out_ready
);
  localparam int GROUPS = 16 / LANES;
  localparam int GW     = (GROUPS > 1) ? $clog2(GROUPS) : 1;
  localparam int GBITS  = LANES * 8;

  if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_bad_lanes
    $error("sub_bytes_iter: LANES must be 1, 2, 4, 8 or 16");
  end

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

  state_t           r_state, w_state_nxt;
  logic [GW-1:0]    r_grp;
  logic [127:0]     r_work;
  logic [GBITS-1:0] w_grp_in, w_grp_out;
  logic             w_last;

  assign w_last   = (r_grp == GW'(GROUPS - 1));
  assign w_grp_in = r_work[int'(r_grp) * GBITS +: GBITS];

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    sub_bytes_sbox u_sbox (
      .i_byte (w_grp_in[8*l +: 8]),
      .o_byte (w_grp_out[8*l +: 8])
    );
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (in_valid)  w_state_nxt = BUSY;
      BUSY:    if (w_last)    w_state_nxt = DONE;
      DONE:    if (out_ready) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= IDLE;
      r_grp   <= '0;
      r_work  <= '0;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        IDLE: if (in_valid) begin
          r_work <= Data_in;
          r_grp  <= '0;
        end
        BUSY: begin
          // substitute group in place; the last group parks the counter at 0
          r_work[int'(r_grp) * GBITS +: GBITS] <= w_grp_out;
          r_grp <= w_last ? '0 : r_grp + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign Data_out  = r_work;
endmodule

// File: tb/tb_sub_bytes_iter.sv
// Bench for sub_bytes_iter at LANES=4, 1 and 16. The reference S-box is
// derived from GF(2^8) inversion plus the affine map, independent of the table.
module tb_sub_bytes_iter;
  localparam int LN[3] = '{4, 1, 16};

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [127:0] din [3];
  logic [127:0] dout[3];
  logic         vin [3];
  logic         rdy [3];
  logic         ov  [3];
  logic         ordy[3];

  sub_bytes_iter #(.LANES(4)) u_dut4 (
    .CLK(clk), .RST(rst), .Data_in(din[0]), .in_valid(vin[0]), .in_ready(rdy[0]),
    .Data_out(dout[0]), .out_valid(ov[0]), .out_ready(ordy[0]));
  sub_bytes_iter #(.LANES(1)) u_dut1 (
    .CLK(clk), .RST(rst), .Data_in(din[1]), .in_valid(vin[1]), .in_ready(rdy[1]),
    .Data_out(dout[1]), .out_valid(ov[1]), .out_ready(ordy[1]));
  sub_bytes_iter #(.LANES(16)) u_dut16 (
    .CLK(clk), .RST(rst), .Data_in(din[2]), .in_valid(vin[2]), .in_ready(rdy[2]),
    .Data_out(dout[2]), .out_valid(ov[2]), .out_ready(ordy[2]));

  int checks = 0;
  int errors = 0;
  logic [127:0] q[$];
  logic [7:0]   sb[256];

  function automatic logic [7:0] gmul(logic [7:0] a, logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] sbox_ref(logic [7:0] x);
    logic [7:0] v = 8'h00;
    if (x != 8'h00)
      for (int c = 1; c < 256; c++) if (gmul(x, 8'(c)) == 8'h01) v = 8'(c);
    return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [127:0] ref128(logic [127:0] d);
    logic [127:0] r;
    for (int k = 0; k < 16; k++) r[8*k +: 8] = sb[d[8*k +: 8]];
    return r;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // accept vector d on instance i (out_ready held 1), then check latency and result
  task automatic run_one(input int i, input logic [127:0] d, input logic [127:0] exp, input string tag);
    int n;
    logic [127:0] e;
    q.push_back(exp);
    @(negedge clk);
    din[i] = d; vin[i] = 1'b1; ordy[i] = 1'b1;
    n = 0;
    while (!rdy[i] && n < 100) begin @(negedge clk); n++; end
    chk({tag, " accept"}, 128'(rdy[i]), 128'd1);
    @(negedge clk);
    vin[i] = 1'b0; din[i] = rnd128();
    n = 0;
    while (!ov[i] && n < 40) begin @(negedge clk); n++; end
    chk({tag, " latency"}, 128'(n), 128'(16 / LN[i]));
    e = (q.size() != 0) ? q.pop_front() : ~exp;
    chk({tag, " data"}, dout[i], e);
    @(negedge clk);
    chk({tag, " drained"}, 128'({ov[i], rdy[i]}), 128'b01);
  endtask

  logic [127:0] vec[8];
  int           acc[8];
  int           got;
  logic [127:0] e;
  logic         seen;

  initial begin
    for (int i = 0; i < 3; i++) begin
      din[i] = '0; vin[i] = 1'b0; ordy[i] = 1'b1;
    end
    for (int b = 0; b < 256; b++) sb[b] = sbox_ref(8'(b));
    rst = 1'b1;
    #1;
    chk("reset state", {dout[0], 1'b0, ov[0], rdy[0]}, {128'd0, 3'b001});
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // known answers at LANES=4
    run_one(0, 128'h0848f8e9_2a8dc69a_2be2f4a0_bee33d19, 128'h3052411e_e55db4b8_f198bfe0_ae1127d4, "L4 fips");
    run_one(0, 128'd0,          {16{8'h63}}, "L4 zero");
    run_one(0, {16{8'hff}},     {16{8'h16}}, "L4 ff");
    run_one(0, {16{8'h53}},     {16{8'hed}}, "L4 53");
    e = rnd128();
    run_one(0, e, ref128(e), "L4 rand");

    // backpressure hold in DONE, in_valid pulses ignored
    e = rnd128();
    q.push_back(ref128(e));
    @(negedge clk);
    din[0] = e; vin[0] = 1'b1; ordy[0] = 1'b0;
    @(negedge clk);
    vin[0] = 1'b0;
    got = 0;
    while (!ov[0] && got < 40) begin @(negedge clk); got++; end
    e = q.pop_front();
    for (int c = 0; c < 10; c++) begin
      chk("hold flags", 128'({ov[0], rdy[0]}), 128'b10);
      chk("hold data", dout[0], e);
      vin[0] = c[0]; din[0] = rnd128();
      @(negedge clk);
    end
    vin[0] = 1'b0;
    chk("hold data end", dout[0], e);
    ordy[0] = 1'b1;
    @(negedge clk);
    chk("hold release", 128'({ov[0], rdy[0]}), 128'b01);
    @(negedge clk);
    chk("hold single xfer", 128'(ov[0]), 128'd0);

    // asynchronous reset while holding a result
    ordy[0] = 1'b0;
    @(negedge clk);
    din[0] = rnd128(); vin[0] = 1'b1;
    @(negedge clk);
    vin[0] = 1'b0;
    repeat (5) @(negedge clk);
    chk("pre-reset done", 128'(ov[0]), 128'd1);
    #2 rst = 1'b1;
    #1;
    chk("async reset", {dout[0], 1'b0, ov[0], rdy[0]}, {128'd0, 3'b001});
    @(negedge clk);
    rst = 1'b0; ordy[0] = 1'b1;

    // reset two cycles into BUSY aborts the block
    @(negedge clk);
    din[0] = rnd128(); vin[0] = 1'b1;
    @(negedge clk);
    vin[0] = 1'b0;
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("abort reset", {dout[0], 1'b0, ov[0], rdy[0]}, {128'd0, 3'b001});
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    repeat (8) begin @(negedge clk); if (ov[0]) seen = 1'b1; end
    chk("abort no output", 128'(seen), 128'd0);
    e = rnd128();
    run_one(0, e, ref128(e), "L4 after abort");

    // back-to-back stream
    for (int j = 0; j < 8; j++) vec[j] = rnd128();
    got = 0;
    @(negedge clk);
    fork
      begin
        int n;
        vin[0] = 1'b1;
        for (int j = 0; j < 8; j++) begin
          din[0] = vec[j];
          q.push_back(ref128(vec[j]));
          n = 0;
          while (!rdy[0] && n < 50) begin @(negedge clk); n++; end
          acc[j] = cyc;
          @(negedge clk);
        end
        vin[0] = 1'b0;
      end
      begin
        int n = 0;
        ordy[0] = 1'b1;
        while (got < 8 && n < 200) begin
          @(negedge clk);
          n++;
          if (ov[0]) begin
            chk("b2b data", dout[0], (q.size() != 0) ? q.pop_front() : ~dout[0]);
            got++;
          end
        end
      end
    join
    chk("b2b count", 128'(got), 128'd8);
    for (int j = 1; j < 8; j++) chk("b2b spacing", 128'(acc[j] - acc[j-1]), 128'd6);

    // other lane counts
    run_one(1, 128'h0848f8e9_2a8dc69a_2be2f4a0_bee33d19, 128'h3052411e_e55db4b8_f198bfe0_ae1127d4, "L1 fips");
    run_one(1, 128'd0,      {16{8'h63}}, "L1 zero");
    run_one(1, {16{8'hff}}, {16{8'h16}}, "L1 ff");
    run_one(1, {16{8'h53}}, {16{8'hed}}, "L1 53");
    run_one(2, 128'h0848f8e9_2a8dc69a_2be2f4a0_bee33d19, 128'h3052411e_e55db4b8_f198bfe0_ae1127d4, "L16 fips");
    run_one(2, 128'd0,      {16{8'h63}}, "L16 zero");
    run_one(2, {16{8'hff}}, {16{8'h16}}, "L16 ff");
    run_one(2, {16{8'h53}}, {16{8'hed}}, "L16 53");
    e = rnd128();
    run_one(2, e, ref128(e), "L16 rand");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, checks %0d errors %0d", checks, errors);
    $fatal(1, "watchdog");
  end
endmodule
